// File: rtl/mem_bus_arbiter.sv
// Serialises MMU-translated data and fetch requests onto one single-outstanding bus,
// data first. Optional abort-on-timeout is built when BUS_TIMEOUT_EN is defined.
module mem_bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TIMEOUT_W      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    input  logic        inst_uncached,
    input  logic        inst_exp,
    input  logic        data_req,
    input  logic        data_we,
    input  logic [3:0]  data_be,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    input  logic        data_uncached,
    input  logic        data_exp,
    output logic        bus_req,
    output logic        bus_we,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic        bus_uncached,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic [31:0] inst_rdata,
    output logic        inst_valid,
    output logic [31:0] data_rdata,
    output logic        data_valid,
    output logic        stall,
    output logic        bus_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUS_D = 2'd1,
        ST_BUS_I = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_d_served;
    logic        r_i_served;
    logic        r_bus_req;
    logic        r_bus_we;
    logic [3:0]  r_bus_be;
    logic [31:0] r_bus_addr;
    logic [31:0] r_bus_wdata;
    logic        r_bus_uncached;
    logic [31:0] r_inst_rdata;
    logic [31:0] r_data_rdata;
    logic        r_inst_valid;
    logic        r_data_valid;

    logic        w_d_live;
    logic        w_i_live;
    logic        w_d_pend;
    logic        w_i_pend;
    logic        w_stall;

    // The timeout counter must be able to represent TIMEOUT_CYCLES.
    generate
        if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES >= (2 ** TIMEOUT_W)) begin : g_bad_cfg
            $error("mem_bus_arbiter: TIMEOUT_CYCLES does not fit in TIMEOUT_W bits");
        end
    endgenerate

    assign w_d_live = data_req & ~data_exp;
    assign w_i_live = inst_req & ~inst_exp;
    assign w_d_pend = w_d_live & ~r_d_served;
    assign w_i_pend = w_i_live & ~r_i_served;
    assign w_stall  = w_d_pend | w_i_pend;

`ifdef BUS_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] r_tmo_cnt;
    logic                 r_bus_err;
    logic                 w_abort;

    // Counter holds (BUS cycles elapsed - 1), so bus_req is high for exactly TIMEOUT_CYCLES cycles.
    assign w_abort = (r_state != ST_IDLE) && !bus_ack &&
                     (r_tmo_cnt == TIMEOUT_W'(TIMEOUT_CYCLES - 1));
    assign bus_err = r_bus_err;
`else
    assign bus_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_d_served     <= 1'b0;
            r_i_served     <= 1'b0;
            r_bus_req      <= 1'b0;
            r_bus_we       <= 1'b0;
            r_bus_be       <= 4'h0;
            r_bus_addr     <= 32'h0;
            r_bus_wdata    <= 32'h0;
            r_bus_uncached <= 1'b0;
            r_inst_rdata   <= 32'h0;
            r_data_rdata   <= 32'h0;
            r_inst_valid   <= 1'b0;
            r_data_valid   <= 1'b0;
`ifdef BUS_TIMEOUT_EN
            r_tmo_cnt      <= '0;
            r_bus_err      <= 1'b0;
`endif
        end else begin
            r_inst_valid <= 1'b0;
            r_data_valid <= 1'b0;
`ifdef BUS_TIMEOUT_EN
            r_bus_err    <= 1'b0;
`endif
            // Pipeline advances when nothing is stalled: forget what was served.
            if (!w_stall) begin
                r_d_served <= 1'b0;
                r_i_served <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_d_pend) begin
                        r_state        <= ST_BUS_D;
                        r_bus_req      <= 1'b1;
                        r_bus_we       <= data_we;
                        r_bus_be       <= data_be;
                        r_bus_addr     <= data_addr;
                        r_bus_wdata    <= data_wdata;
                        r_bus_uncached <= data_uncached;
`ifdef BUS_TIMEOUT_EN
                        r_tmo_cnt      <= '0;
`endif
                    end else if (w_i_pend) begin
                        r_state        <= ST_BUS_I;
                        r_bus_req      <= 1'b1;
                        r_bus_we       <= 1'b0;
                        r_bus_be       <= 4'hF;
                        r_bus_addr     <= inst_addr;
                        r_bus_wdata    <= 32'h0;
                        r_bus_uncached <= inst_uncached;
`ifdef BUS_TIMEOUT_EN
                        r_tmo_cnt      <= '0;
`endif
                    end
                end

                ST_BUS_D: begin
`ifdef BUS_TIMEOUT_EN
                    r_tmo_cnt <= r_tmo_cnt + 1'b1;
`endif
                    if (bus_ack) begin
                        r_data_rdata <= r_bus_we ? 32'h0 : bus_rdata;
                        r_data_valid <= 1'b1;
                        r_d_served   <= 1'b1;
                        r_bus_req    <= 1'b0;
                        r_state      <= ST_IDLE;
                    end
`ifdef BUS_TIMEOUT_EN
                    else if (w_abort) begin
                        r_data_rdata <= 32'h0;
                        r_data_valid <= 1'b1;
                        r_d_served   <= 1'b1;
                        r_bus_req    <= 1'b0;
                        r_bus_err    <= 1'b1;
                        r_state      <= ST_IDLE;
                    end
`endif
                end

                ST_BUS_I: begin
`ifdef BUS_TIMEOUT_EN
                    r_tmo_cnt <= r_tmo_cnt + 1'b1;
`endif
                    if (bus_ack) begin
                        r_inst_rdata <= bus_rdata;
                        r_inst_valid <= 1'b1;
                        r_i_served   <= 1'b1;
                        r_bus_req    <= 1'b0;
                        r_state      <= ST_IDLE;
                    end
`ifdef BUS_TIMEOUT_EN
                    else if (w_abort) begin
                        r_inst_rdata <= 32'h0;
                        r_inst_valid <= 1'b1;
                        r_i_served   <= 1'b1;
                        r_bus_req    <= 1'b0;
                        r_bus_err    <= 1'b1;
                        r_state      <= ST_IDLE;
                    end
`endif
                end

                default: begin
                    r_state   <= ST_IDLE;
                    r_bus_req <= 1'b0;
                end
            endcase
        end
    end

    assign bus_req      = r_bus_req;
    assign bus_we       = r_bus_we;
    assign bus_be       = r_bus_be;
    assign bus_addr     = r_bus_addr;
    assign bus_wdata    = r_bus_wdata;
    assign bus_uncached = r_bus_uncached;
    assign inst_rdata   = r_inst_rdata;
    assign inst_valid   = r_inst_valid;
    assign data_rdata   = r_data_rdata;
    assign data_valid   = r_data_valid;
    assign stall        = w_stall;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: vector table with bus/result scoreboards,
// plus hand sequences for reset, spurious ack and timeout (BUS_TIMEOUT_EN).
module tb_mem_bus_arbiter;

`ifdef BUS_TIMEOUT_EN
    localparam int TMO = 4;
`else
    localparam int TMO = 255;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inst_req = 1'b0;
    logic [31:0] inst_addr = 32'h0;
    logic        inst_uncached = 1'b0;
    logic        inst_exp = 1'b0;
    logic        data_req = 1'b0;
    logic        data_we = 1'b0;
    logic [3:0]  data_be = 4'h0;
    logic [31:0] data_addr = 32'h0;
    logic [31:0] data_wdata = 32'h0;
    logic        data_uncached = 1'b0;
    logic        data_exp = 1'b0;
    logic        bus_req;
    logic        bus_we;
    logic [3:0]  bus_be;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_uncached;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = 32'h0;
    logic [31:0] inst_rdata;
    logic        inst_valid;
    logic [31:0] data_rdata;
    logic        data_valid;
    logic        stall;
    logic        bus_err;

    mem_bus_arbiter #(.TIMEOUT_CYCLES(TMO), .TIMEOUT_W(8)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_uncached(inst_uncached), .inst_exp(inst_exp),
        .data_req(data_req), .data_we(data_we), .data_be(data_be), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_uncached(data_uncached), .data_exp(data_exp),
        .bus_req(bus_req), .bus_we(bus_we), .bus_be(bus_be), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_uncached(bus_uncached), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .inst_rdata(inst_rdata), .inst_valid(inst_valid), .data_rdata(data_rdata),
        .data_valid(data_valid), .stall(stall), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        d_req;
        logic        d_we;
        logic [3:0]  d_be;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic        d_unc;
        logic        d_exp;
        int          d_dly;
        logic [31:0] d_rdata;
        logic        i_req;
        logic [31:0] i_addr;
        logic        i_unc;
        logic        i_exp;
        int          i_dly;
        logic [31:0] i_rdata;
    } vec_t;

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        unc;
        int          dly;
        logic [31:0] rdata;
    } bus_t;

    typedef struct {
        logic        is_data;
        logic [31:0] rdata;
    } res_t;

    bus_t        bus_q[$];
    res_t        res_q[$];
    vec_t        vecs[9];
    logic [31:0] model_i = 32'h0;
    logic [31:0] model_d = 32'h0;
    int          checks = 0;
    int          failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic dr, input logic dw, input logic [3:0] dbe,
                                input logic [31:0] da, input logic [31:0] dwd, input logic du,
                                input logic dx, input int dd, input logic [31:0] drd,
                                input logic ir, input logic [31:0] ia, input logic iu,
                                input logic ix, input int id, input logic [31:0] ird);
        vec_t v;
        v.d_req = dr;  v.d_we = dw;   v.d_be = dbe;  v.d_addr = da;  v.d_wdata = dwd;
        v.d_unc = du;  v.d_exp = dx;  v.d_dly = dd;  v.d_rdata = drd;
        v.i_req = ir;  v.i_addr = ia; v.i_unc = iu;  v.i_exp = ix;   v.i_dly = id;
        v.i_rdata = ird;
        return v;
    endfunction

    task automatic drop_reqs();
        data_req = 1'b0; inst_req = 1'b0; data_exp = 1'b0; inst_exp = 1'b0;
        data_we = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic d_live, i_live, in_txn, done;
        int   wait_cnt;
        bus_t cur;
        bus_t b;
        res_t r;
        d_live = v.d_req & ~v.d_exp;
        i_live = v.i_req & ~v.i_exp;
        data_req = v.d_req; data_we = v.d_we; data_be = v.d_be; data_addr = v.d_addr;
        data_wdata = v.d_wdata; data_uncached = v.d_unc; data_exp = v.d_exp;
        inst_req = v.i_req; inst_addr = v.i_addr; inst_uncached = v.i_unc; inst_exp = v.i_exp;
        if (d_live) begin
            b.we = v.d_we; b.be = v.d_be; b.addr = v.d_addr; b.wdata = v.d_wdata;
            b.unc = v.d_unc; b.dly = v.d_dly; b.rdata = v.d_rdata;
            bus_q.push_back(b);
            r.is_data = 1'b1; r.rdata = v.d_we ? 32'h0 : v.d_rdata;
            res_q.push_back(r);
        end
        if (i_live) begin
            b.we = 1'b0; b.be = 4'hF; b.addr = v.i_addr; b.wdata = 32'h0;
            b.unc = v.i_unc; b.dly = v.i_dly; b.rdata = v.i_rdata;
            bus_q.push_back(b);
            r.is_data = 1'b0; r.rdata = v.i_rdata;
            res_q.push_back(r);
        end
        #1;
        chk1($sformatf("v%0d_stall_start", idx), stall, d_live | i_live);
        if (!d_live && !i_live) begin
            for (int c = 0; c < 4; c++) begin
                step();
                chk1($sformatf("v%0d_no_bus_req", idx), bus_req, 1'b0);
                chk1($sformatf("v%0d_no_stall", idx), stall, 1'b0);
                chk1($sformatf("v%0d_no_valid", idx), data_valid | inst_valid, 1'b0);
            end
        end else begin
            in_txn = 1'b0; done = 1'b0; wait_cnt = 0;
            for (int c = 0; c < 64 && !done; c++) begin
                step();
                bus_ack = 1'b0;
                if (data_valid) begin
                    if (res_q.size() > 0 && res_q[0].is_data) begin
                        r = res_q.pop_front();
                        chk($sformatf("v%0d_data_rdata", idx), data_rdata, r.rdata);
                        model_d = r.rdata;
                    end else chk1($sformatf("v%0d_data_valid_unexpected", idx), 1'b1, 1'b0);
                end
                if (inst_valid) begin
                    if (res_q.size() > 0 && !res_q[0].is_data) begin
                        r = res_q.pop_front();
                        chk($sformatf("v%0d_inst_rdata", idx), inst_rdata, r.rdata);
                        model_i = r.rdata;
                    end else chk1($sformatf("v%0d_inst_valid_unexpected", idx), 1'b1, 1'b0);
                end
                if (bus_req && !in_txn) begin
                    if (bus_q.size() == 0) begin
                        chk1($sformatf("v%0d_bus_req_unexpected", idx), 1'b1, 1'b0);
                    end else begin
                        cur = bus_q.pop_front();
                        chk($sformatf("v%0d_bus_addr", idx), bus_addr, cur.addr);
                        chk1($sformatf("v%0d_bus_we", idx), bus_we, cur.we);
                        chk($sformatf("v%0d_bus_be", idx), {28'h0, bus_be}, {28'h0, cur.be});
                        chk1($sformatf("v%0d_bus_uncached", idx), bus_uncached, cur.unc);
                        if (cur.we) chk($sformatf("v%0d_bus_wdata", idx), bus_wdata, cur.wdata);
                        in_txn = 1'b1; wait_cnt = 0;
                    end
                end
                if (bus_req && in_txn) begin
                    if (wait_cnt == cur.dly) begin
                        bus_ack = 1'b1; bus_rdata = cur.rdata; in_txn = 1'b0;
                    end else wait_cnt++;
                end
                chk1($sformatf("v%0d_stall", idx), stall, res_q.size() != 0);
                if (bus_q.size() == 0 && res_q.size() == 0 && !in_txn) done = 1'b1;
            end
            if (!done) begin
                chk1($sformatf("v%0d_cycle_budget", idx), 1'b0, 1'b1);
                bus_q.delete(); res_q.delete(); bus_ack = 1'b0;
            end
        end
        drop_reqs();
        chk($sformatf("v%0d_inst_rdata_hold", idx), inst_rdata, model_i);
        chk($sformatf("v%0d_data_rdata_hold", idx), data_rdata, model_d);
        step();
        chk1($sformatf("v%0d_valid_one_cycle", idx), data_valid | inst_valid, 1'b0);
        chk1($sformatf("v%0d_idle_bus_req", idx), bus_req, 1'b0);
        $display("vector %0d done: d_live=%b i_live=%b", idx, d_live, i_live);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int hi;
        logic seen;
        //          dreq we  be     addr          wdata         unc exp dly drdata        ireq addr          unc exp dly irdata
        vecs[0] = mk(0, 0, 4'h0, 32'h0,        32'h0,        0, 0, 0, 32'h0,        1, 32'h1FC00000, 1, 0, 1, 32'h3C08BFC0);
        vecs[1] = mk(1, 1, 4'h3, 32'h00001000, 32'hDEADBEEF, 0, 0, 0, 32'h12345678, 1, 32'h1FC00004, 0, 0, 2, 32'h27BDFFE8);
        vecs[2] = mk(1, 0, 4'hF, 32'h00002000, 32'h0,        0, 1, 0, 32'h55555555, 0, 32'h0,        0, 0, 0, 32'h0);
        vecs[3] = mk(1, 0, 4'hF, 32'h80000010, 32'h0,        0, 0, 0, 32'hCAFEF00D, 0, 32'h0,        0, 0, 0, 32'h0);
        vecs[4] = mk(1, 0, 4'hC, 32'h80000020, 32'h0,        1, 0, 3, 32'hA5A50000, 1, 32'h00400000, 0, 1, 0, 32'h0BADF00D);
        vecs[5] = mk(1, 1, 4'hF, 32'h00003000, 32'h01020304, 0, 1, 0, 32'h0,        1, 32'h00400008, 1, 0, 0, 32'h8FBF0010);
        vecs[6] = mk(1, 0, 4'hF, 32'h00004000, 32'h0,        0, 1, 0, 32'h0,        1, 32'h0040000C, 0, 1, 0, 32'h0);
        vecs[7] = mk(1, 0, 4'hF, 32'hA0000040, 32'h0,        1, 0, 2, 32'h76543210, 1, 32'h00400010, 0, 0, 0, 32'h24020001);
        vecs[8] = mk(1, 1, 4'h8, 32'h00005003, 32'hFF000000, 1, 0, 1, 32'hFFFFFFFF, 0, 32'h0,        0, 0, 0, 32'h0);

        step(); step();
        rst = 1'b0;
        chk1("reset_bus_req", bus_req, 1'b0);
        chk1("reset_stall", stall, 1'b0);
        chk1("reset_valids", inst_valid | data_valid, 1'b0);
        chk("reset_inst_rdata", inst_rdata, 32'h0);
        chk("reset_data_rdata", data_rdata, 32'h0);
        chk("reset_bus_addr", bus_addr, 32'h0);
        chk1("reset_bus_err", bus_err, 1'b0);

        for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

        // Spurious ack while idle must be ignored.
        bus_ack = 1'b1; bus_rdata = 32'hFFFFFFFF;
        step();
        bus_ack = 1'b0;
        chk1("spurious_ack_valid", inst_valid | data_valid, 1'b0);
        step();
        chk("spurious_ack_inst_rdata", inst_rdata, model_i);
        chk("spurious_ack_data_rdata", data_rdata, model_d);
        chk1("spurious_ack_bus_req", bus_req, 1'b0);
        $display("sequence spurious_ack done");

        // Reset in BUS_I, ack one cycle later lands in IDLE.
        inst_req = 1'b1; inst_addr = 32'h1FC00100;
        step();
        chk1("rst_busi_bus_req_before", bus_req, 1'b1);
        rst = 1'b1;
        step();
        chk1("rst_busi_bus_req_after", bus_req, 1'b0);
        rst = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h11111111; inst_req = 1'b0;
        model_i = 32'h0; model_d = 32'h0;
        step();
        bus_ack = 1'b0;
        chk1("rst_busi_inst_valid", inst_valid, 1'b0);
        chk1("rst_busi_bus_req_idle", bus_req, 1'b0);
        chk("rst_busi_inst_rdata", inst_rdata, model_i);
        $display("sequence reset_in_bus_i done");

        // Ack in the same cycle as reset during BUS_D.
        data_req = 1'b1; data_we = 1'b0; data_be = 4'hF; data_addr = 32'h00006000;
        step();
        chk1("rst_ack_bus_req_before", bus_req, 1'b1);
        rst = 1'b1; bus_ack = 1'b1; bus_rdata = 32'h22222222; data_req = 1'b0;
        step();
        rst = 1'b0; bus_ack = 1'b0;
        chk1("rst_ack_data_valid", data_valid, 1'b0);
        chk1("rst_ack_bus_req", bus_req, 1'b0);
        chk("rst_ack_data_rdata", data_rdata, 32'h0);
        step();
        chk1("rst_ack_data_valid_late", data_valid, 1'b0);
        $display("sequence reset_with_ack done");

        run_vec(vecs[0], 90);

        // Slave never acks.
        data_req = 1'b1; data_we = 1'b0; data_be = 4'hF; data_addr = 32'h00007000;
        hi = 0; seen = 1'b0;
`ifdef BUS_TIMEOUT_EN
        for (int c = 0; c < 300 && !seen; c++) begin
            step();
            if (bus_err) seen = 1'b1;
            else if (bus_req) hi++;
        end
        chk1("tmo_bus_err_seen", seen, 1'b1);
        chk("tmo_bus_req_cycles", hi, 32'd4);
        chk1("tmo_data_valid", data_valid, 1'b1);
        chk("tmo_data_rdata", data_rdata, 32'h0);
        chk1("tmo_bus_req_dropped", bus_req, 1'b0);
        chk1("tmo_stall", stall, 1'b0);
        drop_reqs();
        step();
        chk1("tmo_bus_err_pulse", bus_err, 1'b0);
`else
        for (int c = 0; c < 20; c++) begin
            step();
            if (bus_req) hi++;
            if (bus_err || data_valid) seen = 1'b1;
        end
        chk("notmo_bus_req_cycles", hi, 32'd20);
        chk1("notmo_no_err_or_valid", seen, 1'b0);
        chk1("notmo_stall", stall, 1'b1);
        drop_reqs();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk1("notmo_reset_recovers", bus_req, 1'b0);
`endif
        $display("sequence no_ack done: bus_req_cycles=%0d", hi);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
